// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, width helper and per-channel state record for the debouncer
//
// Purpose : common definitions imported by debounce_tick and debouncer_multi.
// Contents: default TICK_DIV / STABLE_COUNT / LONG_PRESS_TICKS values,
//           cntWidth() helper for counter sizing, chanState_t record.
// Config  : DEBOUNCER_LONG_PRESS_EN adds the hold counter to chanState_t.
package debounce_pkg;

    localparam int DEFAULT_TICK_DIV         = 5;
    localparam int DEFAULT_STABLE_COUNT     = 7;
    localparam int DEFAULT_LONG_PRESS_TICKS = 250;

    // Widest counter the per-channel record can hold.
    localparam int CNT_W_MAX = 16;

    // Bits needed to hold values 0..maxVal, never less than one bit.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

    typedef struct packed {
        logic                 level;   // accepted debounced level
        logic [CNT_W_MAX-1:0] agree;   // consecutive disagreeing ticks seen
`ifdef DEBOUNCER_LONG_PRESS_EN
        logic [CNT_W_MAX-1:0] hold;    // ticks held while level is 1
`endif
    } chanState_t;

endpackage

// File: rtl/debounce_tick.sv
// rtl/debounce_tick.sv - shared sample-tick generator for the debouncer
//
// Purpose : divides clk by TICK_DIV; tick is high in the cycle the counter
//           sits at TICK_DIV-1, and the counter wraps on that cycle.
// Ports   : clk     - system clock
//           reset_n - asynchronous active-low reset
//           enable  - 1 = count, 0 = hold counter and force tick low
//           tick    - one-cycle sample strobe
module debounce_tick
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = cntWidth(TICK_DIV - 1);

    logic [CW-1:0] count;
    logic          atTop;

    assign atTop = (int'(count) == TICK_DIV - 1);
    assign tick  = enable & atTop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (enable) begin
            count <= atTop ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/debouncer_multi.sv
// rtl/debouncer_multi.sv - multi-channel push-button debouncer with press/release pulses
//
// Purpose : synchronises CHANNELS raw pins, samples them on a shared tick and
//           accepts a new level after STABLE_COUNT consecutive disagreeing ticks.
// Ports   : clk       - system clock
//           reset_n   - asynchronous active-low reset
//           enable    - 1 = sampling runs, 0 = debounce state frozen
//           buttonIn  - raw asynchronous pins (polarity set by INVERT)
//           buttonOut - debounced level, 1 = pressed
//           pressed   - one-cycle pulse on accepted 0->1
//           released  - one-cycle pulse on accepted 1->0
//           longPress - one-cycle pulse after LONG_PRESS_TICKS ticks held
// Config  : DEBOUNCER_LONG_PRESS_EN enables the long-press counter; without it
//           longPress is tied to 0.
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int                  CHANNELS         = 4,
    parameter int                  TICK_DIV         = DEFAULT_TICK_DIV,
    parameter int                  STABLE_COUNT     = DEFAULT_STABLE_COUNT,
    parameter logic [CHANNELS-1:0] INVERT           = '0,
    parameter int                  LONG_PRESS_TICKS = DEFAULT_LONG_PRESS_TICKS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [CHANNELS-1:0] buttonIn,
    output logic [CHANNELS-1:0] buttonOut,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] longPress
);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] sample;
    logic                tick;
    chanState_t          st [CHANNELS];

    debounce_tick #(
        .TICK_DIV (TICK_DIV)
    ) uTick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .tick    (tick)
    );

    // The synchroniser keeps running while enable is low so that a resumed
    // channel never sees a stale pin value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttonIn;
            sync2 <= sync1;
        end
    end

    assign sample = sync2 ^ INVERT;

    always_comb begin
        buttonOut = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            buttonOut[i] = st[i].level;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i] <= '0;
            end
            pressed  <= '0;
            released <= '0;
`ifdef DEBOUNCER_LONG_PRESS_EN
            longPress <= '0;
`endif
        end else begin
            pressed  <= '0;
            released <= '0;
`ifdef DEBOUNCER_LONG_PRESS_EN
            longPress <= '0;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                if (tick) begin
                    if (sample[i] == st[i].level) begin
                        // A bounce back to the current level restarts qualification.
                        st[i].agree <= '0;
                    end else if (int'(st[i].agree) + 1 >= STABLE_COUNT) begin
                        st[i].level <= sample[i];
                        st[i].agree <= '0;
                        pressed[i]  <= sample[i];
                        released[i] <= ~sample[i];
                    end else begin
                        st[i].agree <= st[i].agree + CNT_W_MAX'(1);
                    end
                end
`ifdef DEBOUNCER_LONG_PRESS_EN
                // Saturating at LONG_PRESS_TICKS makes the pulse fire once per
                // press; dropping the level clears the count and re-arms it.
                if (!st[i].level) begin
                    st[i].hold <= '0;
                end else if (tick && (int'(st[i].hold) < LONG_PRESS_TICKS)) begin
                    st[i].hold   <= st[i].hold + CNT_W_MAX'(1);
                    longPress[i] <= (int'(st[i].hold) + 1 == LONG_PRESS_TICKS);
                end
`endif
            end
        end
    end

`ifndef DEBOUNCER_LONG_PRESS_EN
    // Long-press compiled out: output tied low for any sane LONG_PRESS_TICKS.
    if (LONG_PRESS_TICKS >= 0) begin : gLongPressOff
        assign longPress = '0;
    end
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// tb/tb_debouncer_multi.sv - directed self-checking bench for debouncer_multi
module tb_debouncer_multi;

`ifdef DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] btnA, boA, prA, rlA, lpA;
    logic [1:0] btnB, boB, prB, rlB, lpB;

    int nCompared   = 0;
    int nMismatched = 0;

    int prCntA1 = 0;
    int rlCntB0 = 0;
    int lpCntA0 = 0;
    int lpCntA1 = 0;
    int snap0;
    int snap1;

    debouncer_multi #(
        .CHANNELS(2), .TICK_DIV(4), .STABLE_COUNT(3), .INVERT(2'b00), .LONG_PRESS_TICKS(5)
    ) dutA (
        .clk(clk), .reset_n(reset_n), .enable(enable), .buttonIn(btnA),
        .buttonOut(boA), .pressed(prA), .released(rlA), .longPress(lpA)
    );

    debouncer_multi #(
        .CHANNELS(2), .TICK_DIV(4), .STABLE_COUNT(3), .INVERT(2'b01), .LONG_PRESS_TICKS(5)
    ) dutB (
        .clk(clk), .reset_n(reset_n), .enable(enable), .buttonIn(btnB),
        .buttonOut(boB), .pressed(prB), .released(rlB), .longPress(lpB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        prCntA1 += int'(prA[1]);
        rlCntB0 += int'(rlB[0]);
        lpCntA0 += int'(lpA[0]);
        lpCntA1 += int'(lpA[1]);
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        btnA    = 2'b11;
        btnB    = 2'b01;

        // Reset state with pins active.
        clocks(3);
        check("rst_bo",  32'(boA), 0);
        check("rst_pr",  32'(prA), 0);
        check("rst_rl",  32'(rlA), 0);
        check("rst_lp",  32'(lpA), 0);
        check("rst_boB", 32'(boB), 0);

        // First acceptance: ticks on edges 4, 8, 12 after release.
        btnA    = 2'b01;
        reset_n = 1'b1;
        clocks(11);
        check("first_pre", 32'(boA), 0);
        clocks(1);
        check("first_bo", 32'(boA), 1);
        check("first_pr", 32'(prA), 1);
        check("first_rl", 32'(rlA), 0);
        clocks(1);
        check("first_pr_end", 32'(prA), 0);
        check("first_bo_hold", 32'(boA), 1);

        // Bounce on channel 1: 2 agreeing ticks, 1 bounce tick, then steady.
        snap1 = prCntA1;
        btnA = 2'b11;
        clocks(7);
        check("bounce_a", 32'(boA), 1);
        btnA = 2'b01;
        clocks(4);
        check("bounce_b", 32'(boA), 1);
        btnA = 2'b11;
        clocks(11);
        check("bounce_pre", 32'(boA), 1);
        clocks(1);
        check("bounce_bo", 32'(boA), 3);
        check("bounce_pr", 32'(prA), 2);
        clocks(1);
        check("bounce_pr_end", 32'(prA), 0);
        check("bounce_pulses", 32'(prCntA1 - snap1), 1);

        // Active-low channel 0 on dutB: press then release.
        snap0 = rlCntB0;
        btnB = 2'b00;
        clocks(10);
        check("inv_pre", 32'(boB), 0);
        clocks(1);
        check("inv_bo", 32'(boB), 1);
        check("inv_pr", 32'(prB), 1);
        check("inv_rl", 32'(rlB), 0);
        btnB = 2'b01;
        clocks(11);
        check("rel_pre", 32'(boB), 1);
        check("rel_pre_rl", 32'(rlB), 0);
        clocks(1);
        check("rel_bo", 32'(boB), 0);
        check("rel_rl", 32'(rlB), 1);
        check("rel_pr", 32'(prB), 0);
        clocks(1);
        check("rel_rl_end", 32'(rlB), 0);
        check("rel_pulses", 32'(rlCntB0 - snap0), 1);

        // Enable freeze for 10 clk after 2 agreeing ticks on channel 0 release.
        btnA = 2'b10;
        clocks(7);
        check("frz_start", 32'(boA), 3);
        enable = 1'b0;
        clocks(4);
        check("frz_nominal_bo", 32'(boA), 3);
        check("frz_nominal_rl", 32'(rlA), 0);
        clocks(6);
        check("frz_end_bo", 32'(boA), 3);
        enable = 1'b1;
        clocks(3);
        check("frz_pre", 32'(boA), 3);
        clocks(1);
        check("frz_bo", 32'(boA), 2);
        check("frz_rl", 32'(rlA), 1);

        // Simultaneous acceptance: channel 0 presses while channel 1 releases.
        btnA = 2'b01;
        clocks(12);
        check("simul_bo", 32'(boA), 1);
        check("simul_pr", 32'(prA), 1);
        check("simul_rl", 32'(rlA), 2);

        // Channel 1 two ticks into qualification, then async reset.
        btnA = 2'b11;
        clocks(8);
        check("mid_bo", 32'(boA), 1);
        reset_n = 1'b0;
        #1;
        check("async_bo", 32'(boA), 0);
        check("async_pr", 32'(prA), 0);
        check("async_rl", 32'(rlA), 0);
        clocks(2);
        reset_n = 1'b1;
        clocks(11);
        check("rerun_pre", 32'(boA), 0);
        clocks(1);
        check("rerun_bo", 32'(boA), 3);
        check("rerun_pr", 32'(prA), 3);

        // Long press: 5 ticks after the level rose.
        snap0 = lpCntA0;
        snap1 = lpCntA1;
        clocks(19);
        check("lp_pre", 32'(lpA), 0);
        clocks(1);
        check("lp_fire", 32'(lpA), LP_ON ? 3 : 0);
        clocks(1);
        check("lp_end", 32'(lpA), 0);
        clocks(20);
        check("lp_once0", 32'(lpCntA0 - snap0), LP_ON ? 1 : 0);
        check("lp_once1", 32'(lpCntA1 - snap1), LP_ON ? 1 : 0);

        // Release and re-press channel 0 re-arms its long press.
        btnA = 2'b10;
        clocks(11);
        check("lp_rel_bo", 32'(boA), 2);
        check("lp_rel_rl", 32'(rlA), 1);
        btnA = 2'b11;
        clocks(12);
        check("lp_rep_bo", 32'(boA), 3);
        check("lp_rep_pr", 32'(prA), 1);
        clocks(19);
        check("lp2_pre", 32'(lpA), 0);
        clocks(1);
        check("lp2_fire", 32'(lpA), LP_ON ? 1 : 0);
        clocks(1);
        check("lp2_cnt0", 32'(lpCntA0 - snap0), LP_ON ? 2 : 0);
        check("lp2_cnt1", 32'(lpCntA1 - snap1), LP_ON ? 1 : 0);
        check("lpB_idle", 32'(lpB), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
